// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared state encoding and defaults for button/switch front-ends
package btn_debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  localparam int DEBOUNCE_LOG2DELAY  = 18;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/btn_debounce_channel.sv
// rtl/btn_debounce_channel.sv - one channel: synchronizer, stability counter, FSM, press/release strobes
module btn_debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int LOG2DELAY   = DEBOUNCE_LOG2DELAY,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [LOG2DELAY-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  deb_state_e             state_q, state_d;
  logic [LOG2DELAY-1:0]   cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The edge that leaves STABLE is already the first mismatch sample, so
  // acceptance lands on the 2^LOG2DELAY-th consecutive mismatch at all-ones.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (s != level_q) begin
          state_d = PENDING;
          cnt_d   = LOG2DELAY'(1);
        end
      end
      PENDING: begin
        if (s == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = STABLE;
          cnt_d     = '0;
          level_d   = s;
          press_d   = s;
          release_d = ~s;
        end else begin
          cnt_d = cnt_q + LOG2DELAY'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - WIDTH independent debounced button channels with press/release strobes
module btn_debounce #(
  parameter int WIDTH       = 4,
  parameter int LOG2DELAY   = btn_debounce_pkg::DEBOUNCE_LOG2DELAY,
  parameter int SYNC_STAGES = btn_debounce_pkg::SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_debounce_channel #(
      .LOG2DELAY  (LOG2DELAY),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .pin          (btn_in[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - vector table, corner sequences and randomized run against a window-based model
module tb_btn_debounce;

  localparam int W   = 4;
  localparam int L2  = 3;
  localparam int SS  = 2;
  localparam int DLY = 1 << L2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn_in;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;

  always #5 clk = ~clk;

  btn_debounce #(
    .WIDTH      (W),
    .LOG2DELAY  (L2),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  int tests = 0;
  int fails = 0;

  // Model: a channel accepts a new level when the last DLY synchronized samples all differ from it.
  logic [SS-1:0]  m_pipe [W];
  logic [DLY-1:0] m_win  [W];
  logic [W-1:0]   m_level, m_press, m_release;
  logic [W-1:0]   prev_level, prev_pulse;
  logic           prev_rst;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    int         n;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic s;
    for (int ch = 0; ch < W; ch++) begin
      if (rst) begin
        m_pipe[ch]    = '0;
        m_win[ch]     = '0;
        m_level[ch]   = 1'b0;
        m_press[ch]   = 1'b0;
        m_release[ch] = 1'b0;
      end else begin
        s             = m_pipe[ch][SS-1];
        m_win[ch]     = {m_win[ch][DLY-2:0], s};
        m_press[ch]   = 1'b0;
        m_release[ch] = 1'b0;
        if (m_win[ch] == {DLY{~m_level[ch]}}) begin
          m_level[ch]   = s;
          m_press[ch]   = s;
          m_release[ch] = ~s;
        end
        m_pipe[ch] = {m_pipe[ch][SS-2:0], btn_in[ch]};
      end
    end
  endtask

  task automatic step();
    logic cyc_rst;
    @(posedge clk);
    cyc_rst = rst;
    model_edge();
    #1;
    check("model_level", btn_level, m_level);
    check("model_press", btn_press, m_press);
    check("model_release", btn_release, m_release);
    check("press_release_exclusive", btn_press & btn_release, 0);
    check("pulse_two_cycles", (btn_press | btn_release) & prev_pulse, 0);
    if (!cyc_rst) check("level_change_pulse", btn_level ^ prev_level, btn_press | btn_release);
    prev_level = btn_level;
    prev_pulse = btn_press | btn_release;
    prev_rst   = cyc_rst;
  endtask

  function automatic void add(input logic r, input logic [3:0] b, input int n,
                              input logic [3:0] l, input logic [3:0] p, input logic [3:0] q);
    vec_t v;
    v.rst = r; v.btn = b; v.n = n; v.lvl = l; v.prs = p; v.rel = q;
    tbl.push_back(v);
  endfunction

  initial begin
    int cnt;
    rst        = 1'b1;
    btn_in     = '0;
    prev_level = '0;
    prev_pulse = '0;
    prev_rst   = 1'b1;

    // reset
    add(1, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000);
    // clean press on ch0
    add(0, 4'b0001, 9, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
    add(0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
    // clean release on ch0
    add(0, 4'b0000, 9, 4'b0001, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // bounce on ch1, then a long hold
    add(0, 4'b0010, 5, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0010, 5, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 10, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0010, 9, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0010, 1, 4'b0010, 4'b0010, 4'b0000);
    add(0, 4'b0010, 2, 4'b0010, 4'b0000, 4'b0000);
    add(0, 4'b0000, 12, 4'b0000, 4'b0000, 4'b0000);
    // all channels at once
    add(0, 4'b1111, 9, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 4'b1111, 4'b1111, 4'b0000);
    add(0, 4'b0000, 9, 4'b1111, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b1111);
    add(0, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000);
    // reset in the middle of a ch2 debounce
    add(0, 4'b0100, 6, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0100, 1, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0100, 9, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0100, 1, 4'b0100, 4'b0100, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst    = tbl[i].rst;
        btn_in = tbl[i].btn;
        step();
      end
      check($sformatf("vec%0d_level", i), btn_level, tbl[i].lvl);
      check($sformatf("vec%0d_press", i), btn_press, tbl[i].prs);
      check($sformatf("vec%0d_release", i), btn_release, tbl[i].rel);
    end

    // pin held high through a long reset: no pulse during reset, full latency after
    rst    = 1'b1;
    btn_in = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step();
      check("held_rst_level", btn_level, 4'b0000);
      check("held_rst_press", btn_press, 4'b0000);
    end
    rst = 1'b0;
    cnt = 0;
    while (!btn_level[3] && cnt < 30) begin
      step();
      cnt++;
    end
    check("held_rst_latency", cnt, SS + DLY);
    check("held_rst_press_at_rise", btn_press, 4'b1000);

    // randomized pins with occasional reset
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < W; ch++) begin
        if ($urandom_range(0, 9) == 0) btn_in[ch] = ~btn_in[ch];
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side companion to the LED counter path: conditions raw board pushbuttons/switches (asynchronous, bouncy) into clean, clk-synchronous levels and single-cycle press/release strobes.
- Sits directly behind the board input pins.
- Feeds user logic such as counter enable/reset/direction controls.

Parameters:
- WIDTH, 4, number of independent input channels (board buttons).
- LOG2DELAY, 18, log2 of the number of consecutive stable samples required to accept a change.
- SYNC_STAGES, 2, flip-flop depth of the per-channel input synchronizer; legal values 2..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  WIDTH  raw asynchronous button/switch pins.
- btn_level  output  WIDTH  debounced level, registered.
- btn_press  output  WIDTH  one-cycle pulse on accepted 0->1 transition.
- btn_release  output  WIDTH  one-cycle pulse on accepted 1->0 transition.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset values, all registers:
  - synchronizer flops 0
  - btn_level 0
  - per-channel counters 0
  - btn_press 0, btn_release 0
  - channel FSM in STABLE
- Per channel, fully independent:
  - btn_in[i] passes through an SYNC_STAGES-flop synchronizer producing s[i].
  - s[i] is compared against btn_level[i].
- Channel FSM:
  - STABLE: counter held at 0.
    - s == level: remain in STABLE.
    - s != level: go to PENDING; counter becomes 1. This edge counts as the first mismatch sample.
  - PENDING:
    - s == level (bounce): return to STABLE, counter cleared to 0, no pulse.
    - s != level and counter < 2^LOG2DELAY-1: counter increments.
    - s != level and counter == 2^LOG2DELAY-1 (this edge is the 2^LOG2DELAY-th consecutive mismatch sample): level <= s; counter <= 0; state <= STABLE; press or release pulses high for exactly this one cycle.
- Counter: LOG2DELAY bits wide, unsigned. It never wraps, because acceptance occurs at all-ones.
- Latency: a clean step on btn_in appears on btn_level and the matching pulse exactly SYNC_STAGES + 2^LOG2DELAY rising edges after the first edge that samples the new pin value.
- Pulses:
  - Registered, asserted in the same cycle btn_level changes.
  - Never both high on one channel.
  - Never high two cycles in a row.
- Glitch rejection: any excursion of s shorter than 2^LOG2DELAY samples produces no level change and no pulse.
- Simultaneous events: channels change in the same cycle with no interaction. Multiple press/release bits may be high together.
- Reset mid-operation:
  - PENDING is aborted; counter, level and pulses are forced to 0.
  - If the pin is held high through reset, a full debounce (SYNC_STAGES + 2^LOG2DELAY edges after rst deasserts) is required before btn_level rises.
  - No pulse is emitted during reset.
- Startup: a pin already high out of reset produces btn_press once accepted. This is intended.

Decomposition:
- Shared package holds:
  - FSM state encoding: STABLE=1'b0, PENDING=1'b1.
  - Default constants DEBOUNCE_LOG2DELAY=18 and SYNC_STAGES_DEFAULT=2. These are reused by future switch/button front-ends.
- One natural sub-module, btn_debounce_channel:
  - Contains a single-bit synchronizer, counter, FSM and pulse registers.
  - Parameterised by LOG2DELAY and SYNC_STAGES.
  - btn_debounce instantiates WIDTH copies via generate.

Test Plan:
All scenarios use LOG2DELAY=3 and SYNC_STAGES=2, so latency = 2 + 8 = 10 edges.
- Clean press: rst for 2 cycles, then btn_in=4'b0001 held -> btn_level[0] rises exactly 10 edges after first sampling edge; btn_press=4'b0001 for exactly that one cycle; other bits stay 0.
- Clean release: from btn_level=4'b0001, drop btn_in[0] -> btn_level[0] falls 10 edges later; btn_release[0] pulses once; btn_press stays 0.
- Bounce rejection: btn_in[1] toggles high 5 cycles, low 1, high 5, low -> btn_level[1] never changes, no pulses. Then hold high 12 cycles -> accepted 10 edges after the last rise.
- Simultaneous channels: btn_in 4'b0000 -> 4'b1111 on one edge -> btn_level=4'b1111 and btn_press=4'b1111 in the same single cycle.
- Reset mid-debounce: btn_in[2] high, assert rst at 6 edges in for 1 cycle -> btn_level=0 and no pulse during reset; rise occurs exactly 10 edges after the first post-reset sampling edge.
- Pulse/level invariants across random pin stimulus with WIDTH=4:
  - press and release never both high on a channel.
  - No pulse lasts 2 consecutive cycles.
  - Every btn_level change coincides with exactly one pulse.
